regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-port integer register file for the decode stage. Adds

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 78 +++++++
 rtl/regfile_mp_scoreboard.sv | 98 +++++++++
 tb/tb_regfile_mp_scoreboard.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, index/data types and address helper for the multi-port
// register file and its busy scoreboard.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned nregs);
        return addr < nregs;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: tracks destinations issued by decode and
// released by writeback, and reports source/destination hazards.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR-1:0]    wr_release,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic              issue_ready,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] clr;
    logic             issue_zero;
    logic             issue_ok;
    logic             issue_busy;
    logic             issue_clr;
    logic             accept;

    always_comb begin
        clr = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_release[p] && addr_in_range(32'(wr_addr[p*AW +: AW]), NREGS)) begin
                clr[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
    end

    assign issue_zero  = (ZERO_REG != 0) && (issue_rd == '0);
    assign issue_ok    = addr_in_range(32'(issue_rd), NREGS);
    assign issue_busy  = issue_ok && busy_q[issue_rd];
    assign issue_clr   = issue_ok && clr[issue_rd];
    assign issue_ready = !issue_valid || issue_zero || !issue_busy || issue_clr;
    assign accept      = issue_valid && issue_ready && !issue_zero && issue_ok;

    // A new producer claiming a register in its release cycle keeps it busy.
    always_comb begin
        busy_d = busy_q & ~clr;
        if (accept) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        if (reset) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        busy_q <= busy_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
        logic [AW-1:0] addr;
        assign addr       = rd_addr[k*AW +: AW];
        assign rd_busy[k] = addr_in_range(32'(addr), NREGS) && busy_q[addr]
                            && !((BYPASS != 0) && clr[addr]);
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file for decode: prioritised write ports,
// combinational reads with optional write bypass, plus the busy scoreboard.
module regfile_mp_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_release,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    function automatic logic addr_writable(input logic [AW-1:0] a);
        return addr_in_range(32'(a), NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Ports are visited in ascending order so the highest index wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && addr_writable(wr_addr[p*AW +: AW])) begin
                regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            end
        end
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = '0;
            if (addr_writable(addr)) begin
                data = regs_q[addr];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
                            data = wr_data[p*XLEN +: XLEN];
                        end
                    end
                end
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_release  (wr_release),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rd_addr     (rd_addr),
        .issue_ready (issue_ready),
        .rd_busy     (rd_busy),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard (2 read, 2 write ports, bypass on);
// expectations are queued with the stimulus and consumed by a negedge monitor.
module tb_regfile_mp_scoreboard;
    import rf_pkg::*;

    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = AW_DEF;

    localparam int K_RD0   = 0;
    localparam int K_RD1   = 1;
    localparam int K_RBUSY = 2;
    localparam int K_READY = 3;
    localparam int K_BUSYV = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*32-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en = '0;
    logic [NWR*AW-1:0]   wr_addr = '0;
    logic [NWR*32-1:0]   wr_data = '0;
    logic [NWR-1:0]      wr_release = '0;
    logic                issue_valid = 1'b0;
    logic [AW-1:0]       issue_rd = '0;
    logic                issue_ready;
    logic [NREGS_DEF-1:0] busy_vec;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    regfile_mp_scoreboard #(
        .XLEN     (32),
        .NREGS    (32),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_release  (wr_release),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .busy_vec    (busy_vec)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic applyStimulus(input logic rst, input logic [1:0] we,
                                 input reg_idx_t wa0, input xlen_t wd0,
                                 input reg_idx_t wa1, input xlen_t wd1,
                                 input logic [1:0] rel, input logic iv, input reg_idx_t ird,
                                 input reg_idx_t ra0, input reg_idx_t ra1);
        @(posedge clock);
        #1;
        reset       = rst;
        wr_en       = we;
        wr_addr     = {wa1, wa0};
        wr_data     = {wd1, wd0};
        wr_release  = rel;
        issue_valid = iv;
        issue_rd    = ird;
        rd_addr     = {ra1, ra0};
    endtask

    task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: consume every expectation due in the current cycle.
    always @(negedge clock) begin
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc <= cyc) begin
                case (exp_q[i].kind)
                    K_RD0:   act = rd_data[31:0];
                    K_RD1:   act = rd_data[63:32];
                    K_RBUSY: act = {30'b0, rd_busy};
                    K_READY: act = {31'b0, issue_ready};
                    default: act = busy_vec;
                endcase
                checks++;
                if (exp_q[i].cyc != cyc) begin
                    failures++;
                    $display("[TB] FAIL %s: stale check for cycle %0d seen at cycle %0d", exp_q[i].name, exp_q[i].cyc, cyc);
                end else if (act !== exp_q[i].exp) begin
                    failures++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", exp_q[i].name, act, exp_q[i].exp);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset held, then released
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 5, 0);
        checkOutput(K_RD0,   32'h0, "reset_rd0");
        checkOutput(K_RD1,   32'h0, "reset_rd1");
        checkOutput(K_RBUSY, 32'h0, "reset_rd_busy");
        checkOutput(K_READY, 32'h1, "reset_issue_ready");
        checkOutput(K_BUSYV, 32'h0, "reset_busy_vec");

        // Write x5, bypassed the same cycle, stored the next
        applyStimulus(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0, 5, 0);
        checkOutput(K_RD0, 32'hDEADBEEF, "x5_bypass");
        checkOutput(K_RD1, 32'h0,        "x0_read");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 5, 5);
        checkOutput(K_RD0, 32'hDEADBEEF, "x5_port0");
        checkOutput(K_RD1, 32'hDEADBEEF, "x5_port1");

        // Zero register ignores writes and issues
        applyStimulus(0, 2'b01, 0, 32'h1234, 0, 0, 2'b00, 1, 0, 0, 0);
        checkOutput(K_RD0,   32'h0, "x0_write_bypass");
        checkOutput(K_READY, 32'h1, "x0_issue_ready");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5);
        checkOutput(K_RD0,   32'h0,        "x0_after_write");
        checkOutput(K_RD1,   32'hDEADBEEF, "x5_kept");
        checkOutput(K_BUSYV, 32'h0,        "x0_never_busy");

        // Port 1 write bypass
        applyStimulus(0, 2'b10, 0, 0, 7, 32'hA5A5A5A5, 2'b00, 0, 0, 7, 5);
        checkOutput(K_RD0, 32'hA5A5A5A5, "x7_bypass_p1");
        checkOutput(K_RD1, 32'hDEADBEEF, "x5_unaffected");

        // Both ports hit x3: port 1 wins
        applyStimulus(0, 2'b11, 3, 32'h11, 3, 32'h22, 2'b00, 0, 0, 3, 7);
        checkOutput(K_RD0, 32'h22,       "x3_bypass_prio");
        checkOutput(K_RD1, 32'hA5A5A5A5, "x7_stored");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3, 3);
        checkOutput(K_RD0, 32'h22, "x3_prio_p0");
        checkOutput(K_RD1, 32'h22, "x3_prio_p1");

        // Scoreboard on x9
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 9, 9, 3);
        checkOutput(K_READY, 32'h1, "x9_issue_ready");
        checkOutput(K_BUSYV, 32'h0, "x9_not_yet_busy");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 9, 9, 0);
        checkOutput(K_BUSYV, 32'h200, "x9_busy");
        checkOutput(K_RBUSY, 32'h1,   "x9_rd_busy");
        checkOutput(K_READY, 32'h0,   "x9_waw_stall");
        applyStimulus(0, 2'b01, 9, 32'h99, 0, 0, 2'b01, 1, 9, 9, 9);
        checkOutput(K_READY, 32'h1,   "x9_release_ready");
        checkOutput(K_RBUSY, 32'h0,   "x9_release_rd_busy");
        checkOutput(K_RD0,   32'h99,  "x9_release_bypass");
        checkOutput(K_BUSYV, 32'h200, "x9_busy_pre_edge");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 9, 0);
        checkOutput(K_BUSYV, 32'h200, "x9_set_wins");
        checkOutput(K_RBUSY, 32'h1,   "x9_still_busy");
        checkOutput(K_RD0,   32'h99,  "x9_stored");
        applyStimulus(0, 2'b10, 0, 0, 9, 32'h100, 2'b10, 0, 0, 9, 3);
        checkOutput(K_RBUSY, 32'h0,   "x9_rel_p1_rd_busy");
        checkOutput(K_RD0,   32'h100, "x9_rel_p1_bypass");
        checkOutput(K_RD1,   32'h22,  "x3_unchanged");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 9, 3);
        checkOutput(K_BUSYV, 32'h0,   "x9_released");
        checkOutput(K_RBUSY, 32'h0,   "x9_rd_busy_clear");
        checkOutput(K_RD0,   32'h100, "x9_final");

        // x4/x6 busy, write without release, then reset flush
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 4, 4, 6);
        checkOutput(K_READY, 32'h1, "x4_issue_ready");
        applyStimulus(0, 2'b01, 4, 32'h44, 0, 0, 2'b00, 1, 6, 4, 6);
        checkOutput(K_BUSYV, 32'h10, "x4_busy");
        checkOutput(K_RBUSY, 32'h1,  "x4_rd_busy_norel");
        checkOutput(K_RD0,   32'h44, "x4_norel_bypass");
        checkOutput(K_READY, 32'h1,  "x6_issue_ready");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4, 6);
        checkOutput(K_BUSYV, 32'h50, "x4_x6_busy");
        checkOutput(K_RBUSY, 32'h3,  "x4_x6_rd_busy");
        checkOutput(K_RD0,   32'h44, "x4_written_busy");
        applyStimulus(1, 2'b01, 4, 32'hFFFF, 0, 0, 2'b01, 1, 10, 4, 6);
        checkOutput(K_RBUSY, 32'h2,    "reset_cycle_rd_busy");
        checkOutput(K_RD0,   32'hFFFF, "reset_cycle_bypass");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 4, 4, 3);
        checkOutput(K_BUSYV, 32'h0, "flush_busy_vec");
        checkOutput(K_RD0,   32'h0, "flush_x4");
        checkOutput(K_RD1,   32'h0, "flush_x3");
        checkOutput(K_RBUSY, 32'h0, "flush_rd_busy");
        checkOutput(K_READY, 32'h1, "flush_issue_ready");

        @(negedge clock);
        #1;
        while (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: got unchecked expected checked", exp_q[0].name);
            void'(exp_q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
